// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared constants, state encoding and cell format
// for the byte-stream text console writer.
package vga_text_pkg;

  localparam int DEF_COLS   = 80;
  localparam int DEF_ROWS   = 25;
  localparam int DEF_ADDR_W = 12;
  localparam int COL_W      = 7;
  localparam int ROW_W      = 5;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CLR_ATTR = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_CLEAR,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_FILL_LAST
  } state_t;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
  } cell_t;

endpackage

// File: rtl/vga_text_writer_cursor.sv
// vga_text_cursor: column/row tracking with advance, wrap, back,
// carriage return, line feed and home; exposes the cell address.
module vga_text_cursor
  import vga_text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adv,
  input  logic              back,
  input  logic              cr,
  input  logic              lf,
  input  logic              home,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              last_row,
  output logic              last_cell,
  output logic [ADDR_W-1:0] addr
);

  assign last_row  = row == ROW_W'(ROWS - 1);
  assign last_cell = last_row && (col == COL_W'(COLS - 1));
  assign addr      = ADDR_W'(row) * ADDR_W'(COLS)
                   + ADDR_W'(col);

  // Running off the bottom keeps the row; the scroll moves the text.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else begin
      unique case (1'b1)
        home: begin
          col <= '0;
          row <= '0;
        end
        cr: col <= '0;
        lf: begin
          col <= '0;
          if (!last_row) row <= row + ROW_W'(1);
        end
        back: if (col != '0) col <= col - COL_W'(1);
        adv: begin
          if (col == COL_W'(COLS - 1)) begin
            col <= '0;
            if (!last_row) row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_text_writer.sv
// vga_text_writer: byte-stream console front end writing {attr,char}
// cells into the 80x25 text RAM, with clear, wrap and scroll.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int         COLS       = DEF_COLS,
  parameter int         ROWS       = DEF_ROWS,
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_data,
  input  logic [7:0]        cmd_attr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row
);

  localparam int TOTAL = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] S_END = ADDR_W'(TOTAL - COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_N = ADDR_W'(COLS);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  cell_t             wdata_q;
  logic [7:0]        attr_q;
  logic              fwd;
  logic              pend;

  logic accept, is_cr, is_lf, is_bs, is_ff, is_chr;
  logic clr_done, last_row, last_cell;
  logic [ADDR_W-1:0] cur_addr;

  assign cmd_ready = state == ST_IDLE;
  assign accept    = cmd_valid && cmd_ready;
  assign is_cr     = cmd_data == CH_CR;
  assign is_lf     = cmd_data == CH_LF;
  assign is_bs     = cmd_data == CH_BS;
  assign is_ff     = cmd_data == CH_FF;
  assign is_chr    = !(is_cr || is_lf || is_bs || is_ff);
  assign clr_done  = (state == ST_CLEAR) && (cnt == LAST);

  // Scroll write data comes straight from the RAM read of the prior cycle.
  assign ram_wdata = fwd ? ram_rdata : wdata_q;

  vga_text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk       (clk),
    .reset_n   (reset_n),
    .adv       (accept && is_chr),
    .back      (accept && is_bs),
    .cr        (accept && is_cr),
    .lf        (accept && is_lf),
    .home      (clr_done),
    .col       (cursor_col),
    .row       (cursor_row),
    .last_row  (last_row),
    .last_cell (last_cell),
    .addr      (cur_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      cnt      <= '0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      wdata_q  <= '0;
      attr_q   <= '0;
      fwd      <= 1'b0;
      pend     <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      fwd    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            attr_q <= cmd_attr;
            unique case (1'b1)
              is_cr: ;
              is_lf: begin
                if (last_row) begin
                  state <= ST_SCROLL_RD;
                  cnt   <= '0;
                end
              end
              is_bs: begin
                if (cursor_col != '0) begin
                  ram_we   <= 1'b1;
                  ram_addr <= cur_addr - ADDR_W'(1);
                  wdata_q  <= '{attr: cmd_attr, chr: BLANK_CHAR};
                  pend     <= 1'b0;
                  state    <= ST_PUT;
                end
              end
              is_ff: begin
                state <= ST_CLEAR;
                cnt   <= '0;
              end
              default: begin
                ram_we   <= 1'b1;
                ram_addr <= cur_addr;
                wdata_q  <= '{attr: cmd_attr, chr: cmd_data};
                pend     <= last_cell;
                state    <= ST_PUT;
              end
            endcase
          end
        end
        ST_PUT: begin
          cnt   <= '0;
          state <= pend ? ST_SCROLL_RD : ST_IDLE;
        end
        ST_CLEAR: begin
          ram_we   <= 1'b1;
          ram_addr <= cnt;
          wdata_q  <= '{attr: CLR_ATTR, chr: BLANK_CHAR};
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        ST_SCROLL_RD: begin
          ram_addr <= cnt + ROW_N;
          state    <= ST_SCROLL_WR;
        end
        ST_SCROLL_WR: begin
          ram_addr <= cnt;
          ram_we   <= 1'b1;
          fwd      <= 1'b1;
          cnt      <= cnt + ADDR_W'(1);
          state    <= (cnt == S_END) ? ST_FILL_LAST
                                     : ST_SCROLL_RD;
        end
        ST_FILL_LAST: begin
          ram_we   <= 1'b1;
          ram_addr <= cnt;
          wdata_q  <= '{attr: attr_q, chr: BLANK_CHAR};
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
